// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with a one-entry valid/ready output stage.
// RR=0 selects the highest set request; RR=1 rotates priority after each capture.
module prio_encoder_rr #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] code,
  output logic [N-1:0] grant,
  output logic         multi
);

  generate
    if ((N < 2) || (N > 32) || (W != $clog2(N))) begin : g_bad_params
      $error("prio_encoder_rr: N must be 2..32 and W must equal clog2(N)");
    end
  endgenerate

  logic         r_valid;
  logic [W-1:0] r_code;
  logic [N-1:0] r_grant;
  logic         r_multi;
  logic [W-1:0] r_ptr;

  logic         w_capture;
  logic         w_multi;
  logic [W-1:0] w_fp_idx;
  logic [W-1:0] w_rr_idx;
  logic [W-1:0] w_win;
  logic [W-1:0] w_ptr_nxt;

  // A held result blocks capture until the consumer accepts it.
  assign w_capture = en & (|req) & (~r_valid | out_ready);

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(req & (req - N'(1)));

  // Fixed priority: later (higher) indices override earlier ones.
  always_comb begin
    w_fp_idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_fp_idx = req[i] ? W'(i) : w_fp_idx;
    end
  end

  // Round-robin: first set request at or above r_ptr, wrapping N-1 -> 0.
  always_comb begin : p_rr_search
    logic [W:0] v_cand;
    logic       v_found;
    v_cand   = {(W+1){1'b0}};
    v_found  = 1'b0;
    w_rr_idx = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      v_cand   = {1'b0, r_ptr} + (W+1)'(k);
      v_cand   = (v_cand >= (W+1)'(N)) ? (v_cand - (W+1)'(N)) : v_cand;
      w_rr_idx = (!v_found && req[v_cand[W-1:0]]) ? v_cand[W-1:0] : w_rr_idx;
      v_found  = v_found | req[v_cand[W-1:0]];
    end
  end

  assign w_win     = (RR != 0) ? w_rr_idx : w_fp_idx;
  assign w_ptr_nxt = (w_win == W'(N-1)) ? {W{1'b0}} : (w_win + W'(1));

  // Output stage and pointer: capture, drain, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= {W{1'b0}};
      r_grant <= {N{1'b0}};
      r_multi <= 1'b0;
      r_ptr   <= {W{1'b0}};
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_code  <= w_win;
      r_grant <= N'(1) << w_win;
      r_multi <= w_multi;
      r_ptr   <= (RR != 0) ? w_ptr_nxt : {W{1'b0}};
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign code      = r_code;
  assign grant     = r_grant;
  assign multi     = r_multi;

endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 Parameter N, default 8, number of request inputs; legal range 2..32.
REQ-002 Parameter W, default 3, code width; SHALL equal clog2(N), and elaboration SHALL fail otherwise.
REQ-003 Parameter RR, default 0, arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  capture enable; when 0, no new request is captured.
REQ-007 req  input  N  request vector; bit i = input ai.
REQ-008 out_ready  input  1  consumer accepts the held code this cycle.
REQ-009 out_valid  output  1  code/grant/multi hold a captured result.
REQ-010 code  output  W  binary index of the winning request.
REQ-011 grant  output  N  one-hot of the winning request.
REQ-012 multi  output  1  more than one req bit was set at capture.

Function
REQ-013 Capture condition: en=1 and req!=0 and (out_valid=0 or out_ready=1).
  - On capture at edge k, code, grant, multi and out_valid=1 SHALL be updated at edge k.
  - Latency from req to out_valid is 1 cycle.
REQ-014 With RR=0, the winner SHALL be the highest set index; an 8-input instance SHALL reproduce the 8x3 encoder mapping (a7 -> 7, a0 -> 0).
REQ-015 With RR=1, the winner SHALL be the first set index found searching upward from ptr, wrapping N-1 -> 0.
  - ptr is an internal W-bit pointer.
REQ-016 On each RR capture, ptr SHALL become (winner+1) mod N; winner = N-1 SHALL give ptr = 0.
  - ptr SHALL NOT change without a capture.
  - With RR=0, ptr is unused and held at 0.
REQ-017 Drain: if out_valid=1, out_ready=1 and no capture, out_valid SHALL go to 0 at the next edge.
  - code, grant and multi SHALL hold their last values.
REQ-018 Stall: if out_valid=1 and out_ready=0, code, grant, multi and out_valid SHALL hold regardless of req and en.
REQ-019 Simultaneous accept and capture (out_valid=1, out_ready=1, capture condition true):
  - The new result SHALL replace the old one in the same edge.
  - out_valid SHALL stay 1, giving back-to-back throughput of one result per cycle.
REQ-020 en=0 SHALL block capture only; draining per REQ-017 SHALL still occur.
REQ-021 req=0 with en=1 SHALL NOT capture and SHALL NOT move ptr.
REQ-022 grant SHALL always equal the one-hot decode of code whenever out_valid=1.
REQ-023 multi SHALL be 1 iff popcount(req) >= 2 at capture.
REQ-024 req is sampled only at the capture edge; changes between captures SHALL have no effect.

Reset
REQ-025 While rst_n=0, the following SHALL be forced to 0 immediately, without waiting for clk:
  - out_valid, code, grant, multi, ptr.
REQ-026 Reset asserted mid-stall SHALL discard the held result; after release, ptr SHALL restart at 0.
REQ-027 The first capture SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-028 Reset and walking one, RR=0, N=8, en=1, out_ready=1:
  - Stimulus: rst_n low then released; req walks one-hot 0x01..0x80, one bit per cycle.
  - Response: code 0..7 each one cycle later; grant matches; multi=0; out_valid=1 throughout.
REQ-029 Fixed priority, RR=0, N=8:
  - Stimulus: req=0x0B (bits 0,1,3).
  - Response: code=3, grant=0x08, multi=1.
REQ-030 Round-robin, RR=1, N=8, out_ready=1:
  - Stimulus: req held at 0x89 (bits 0,3,7).
  - Response: successive codes 0, 3, 7, 0, 3; ptr after each = 1, 4, 0, 1, 4.
REQ-031 Stall and simultaneous events, RR=0, N=8:
  - Stimulus: capture req=0x04, then out_ready=0 for 3 cycles while req=0x40.
  - Response: code stays 2 during the stall; on the cycle out_ready=1, code=6 captures with out_valid held at 1.
REQ-032 Enable and empty, RR=0, N=8:
  - Stimulus: en=0 with req=0xFF and out_ready=1.
  - Response: out_valid drops to 0 after one edge and stays 0.
  - Stimulus: then en=1 with req=0.
  - Response: out_valid stays 0; ptr unchanged in RR=1.
REQ-033 Asynchronous reset mid-operation, RR=1, N=8:
  - Stimulus: out_valid=1, ptr=5; rst_n pulsed low between clock edges.
  - Response: all outputs 0 before the next edge; first capture with req=0xFF yields code=0.
